// File: rtl/memctrl_pkg.sv
// Shared types and constants for the mem_ctrl load/store front end.
// The MEMCTRL_ERR_EN macro selects address-error checking in mem_ctrl.
package memctrl_pkg;

  localparam int unsigned BRAM_LAT    = 2;
  localparam int unsigned WORD_AW     = 18;
  localparam int unsigned PIPE_STAGES = BRAM_LAT + 1;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

endpackage

// File: rtl/mem_ctrl_resp_fifo.sv
// In-order response buffer between the BRAM read pipeline and the core.
// Power-of-two DEPTH so the pointers wrap naturally.
module resp_fifo
  import memctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  resp_t                    push_data,
  input  logic                     pop,
  output resp_t                    pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  resp_t         mem_q [DEPTH];
  resp_t         mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_pop_c;

  always_comb begin
    do_pop_c = pop && (count_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop_c) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push && !do_pop_c) begin
      count_d = count_q + CW'(1);
    end else if (!push && do_pop_c) begin
      count_d = count_q - CW'(1);
    end
  end

  // Storage needs no reset: an entry is only visible after it has been written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/mem_ctrl.sv
// Load/store front end for the bram data memory with credit-based response buffering.
// Define MEMCTRL_ERR_EN to flag misaligned / out-of-range requests instead of issuing them.
module mem_ctrl
  import memctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        err_sticky,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_we,
  input  logic [31:0] mem_dout
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = CW + 1;
  localparam int unsigned IW = $clog2(PIPE_STAGES + 1);

  logic                   accept_c;
  logic                   req_err_c;
  logic [PIPE_STAGES-1:0] load_q, load_d;
  logic [PIPE_STAGES-1:0] perr_q, perr_d;
  logic [31:0]            mem_addr_q, mem_addr_d;
  logic [31:0]            mem_din_q, mem_din_d;
  logic                   mem_we_q, mem_we_d;
  logic [IW-1:0]          inflight_c;
  logic [SW-1:0]          credit_c;
  logic [CW-1:0]          fifo_count;
  logic                   fifo_empty;
  resp_t                  push_data_c;
  resp_t                  head_c;

`ifdef MEMCTRL_ERR_EN
  logic sticky_q, sticky_d;

  assign req_err_c = (req_addr[1:0] != 2'b00) || (req_addr[31:20] != 12'h000);

  always_comb begin
    sticky_d = sticky_q | (accept_c & req_we & req_err_c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign err_sticky = sticky_q;
`else
  logic unused_addr_c;

  assign req_err_c     = 1'b0;
  assign unused_addr_c = ^{req_addr[31:20], req_addr[1:0]};
  assign err_sticky    = 1'b0;
`endif

  // Credit counts every outstanding load, so a response always has a FIFO slot.
  always_comb begin
    inflight_c = '0;
    for (int i = 0; i < int'(PIPE_STAGES); i++) begin
      inflight_c = inflight_c + IW'(load_q[i]);
    end
    credit_c = SW'(fifo_count) + SW'(inflight_c);
  end

  assign req_ready = ~rst & (credit_c < SW'(DEPTH));
  assign accept_c  = req_valid & req_ready;

  always_comb begin
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    if (accept_c && !req_err_c) begin
      mem_we_d   = req_we;
      mem_addr_d = 32'(req_addr[WORD_AW+1:2]);
      mem_din_d  = req_wdata;
    end
    load_d = {load_q[PIPE_STAGES-2:0], accept_c & ~req_we};
    perr_d = {perr_q[PIPE_STAGES-2:0], accept_c & ~req_we & req_err_c};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      load_q     <= '0;
      perr_q     <= '0;
    end else begin
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      load_q     <= load_d;
      perr_q     <= perr_d;
    end
  end

  // The last stage lines up with mem_dout; errored loads return zero data.
  always_comb begin
    push_data_c.err   = perr_q[PIPE_STAGES-1];
    push_data_c.rdata = perr_q[PIPE_STAGES-1] ? 32'h0 : mem_dout;
  end

  resp_fifo #(
    .DEPTH(DEPTH)
  ) u_resp_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (load_q[PIPE_STAGES-1]),
    .push_data(push_data_c),
    .pop      (resp_ready),
    .pop_data (head_c),
    .count    (fifo_count),
    .empty    (fifo_empty)
  );

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_din    = mem_din_q;
  assign resp_valid = ~fifo_empty;
  assign resp_rdata = head_c.rdata;
  assign resp_err   = head_c.err;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl with a behavioural bram and a transaction-level model.
// Honours MEMCTRL_ERR_EN the same way the design does.
`timescale 1ns/1ps
module tb_mem_ctrl;

  localparam int DEPTH = 8;
  localparam int MW    = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        err_sticky;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_we;
  logic [31:0] mem_dout;
  logic        preload;

  always #5 clk = ~clk;

  mem_ctrl #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .err_sticky(err_sticky),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_we    (mem_we),
    .mem_dout  (mem_dout)
  );

  function automatic logic [31:0] pattern(input int i);
    return 32'hA500_0000 | 32'(i);
  endfunction

  function automatic logic addr_err(input logic [31:0] a);
`ifdef MEMCTRL_ERR_EN
    return (a[1:0] != 2'b00) || (a[31:20] != 12'h000);
`else
    return 1'b0;
`endif
  endfunction

  // Behavioural bram: address register, then registered data (2-edge latency).
  logic [31:0] bram [MW];
  logic [9:0]  bram_raddr_q;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < MW; i++) bram[i] <= pattern(i);
    end else begin
      if (mem_we) bram[mem_addr[9:0]] <= mem_din;
      bram_raddr_q <= mem_addr[9:0];
      mem_dout     <= bram[bram_raddr_q];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          avail;
  } exp_t;

  exp_t        exp_q [$];
  logic [31:0] ref_mem [MW];
  logic        exp_sticky;
  int          cyc = 0;
  logic [31:0] log_d [$];
  logic        log_e [$];
  int          log_c [$];

  // Model: outstanding loads are a queue; each becomes visible 4 cycles after acceptance.
  always @(negedge clk) begin
    logic ev;
    logic rerr;
    exp_t ent;
    if (preload) begin
      for (int i = 0; i < MW; i++) ref_mem[i] = pattern(i);
    end
    if (rst) begin
      chk("rst_req_ready", 32'(req_ready), 32'(0));
      chk("rst_resp_valid", 32'(resp_valid), 32'(0));
      exp_q.delete();
      exp_sticky = 1'b0;
    end else begin
      ev = (exp_q.size() != 0) && (exp_q[0].avail <= cyc);
      chk("resp_valid", 32'(resp_valid), 32'(ev));
      if (ev) begin
        chk("resp_rdata", resp_rdata, exp_q[0].d);
        chk("resp_err", 32'(resp_err), 32'(exp_q[0].e));
      end
      chk("req_ready", 32'(req_ready), 32'(exp_q.size() < DEPTH));
      chk("err_sticky", 32'(err_sticky), 32'(exp_sticky));
      if (resp_valid && resp_ready) begin
        log_d.push_back(resp_rdata);
        log_e.push_back(resp_err);
        log_c.push_back(cyc);
        if (ev) void'(exp_q.pop_front());
      end
      if (req_valid && req_ready) begin
        rerr = addr_err(req_addr);
        if (req_we) begin
          if (rerr) exp_sticky = 1'b1;
          else      ref_mem[req_addr[11:2]] = req_wdata;
        end else begin
          ent.d     = rerr ? 32'h0 : ref_mem[req_addr[11:2]];
          ent.e     = rerr;
          ent.avail = cyc + 4;
          exp_q.push_back(ent);
        end
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    int acc;
    logic [31:0] a0;
    rst = 1'b1; preload = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 preload = 1'b0;
    tick();

    // Reset state
    chk("rst_mem_we", 32'(mem_we), 32'(0));
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_din", mem_din, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", 32'(resp_err), 32'(0));
    chk("rst_err_sticky", 32'(err_sticky), 32'(0));
    rst = 1'b0;
    #1;
    chk("ready_after_release", 32'(req_ready), 32'(1));

    // Store then dependent load
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h100; req_wdata = 32'hDEADBEEF;
    tick();
    chk("store_mem_we", 32'(mem_we), 32'(1));
    chk("store_mem_addr", mem_addr, 32'h40);
    chk("store_mem_din", mem_din, 32'hDEADBEEF);
    req_we = 1'b0;
    tick();
    req_valid = 1'b0;
    chk("store_we_one_cycle", 32'(mem_we), 32'(0));
    chk("load_mem_addr", mem_addr, 32'h40);
    for (int i = 1; i <= 3; i++) begin
      chk("load_latency_early", 32'(resp_valid), 32'(0));
      tick();
    end
    chk("load_latency_valid", 32'(resp_valid), 32'(1));
    chk("load_raw_data", resp_rdata, 32'hDEADBEEF);
    repeat (2) tick();

    // 16 back-to-back loads
    base = log_d.size();
    for (int i = 0; i < 16; i++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'(i * 4);
      chk("b2b_ready", 32'(req_ready), 32'(1));
      tick();
    end
    req_valid = 1'b0;
    repeat (6) tick();
    chk("b2b_count", 32'(log_d.size() - base), 32'(16));
    for (int i = 0; i < 16; i++) begin
      if (base + i < log_d.size()) begin
        chk("b2b_data", log_d[base+i], pattern(i));
        chk("b2b_consecutive", 32'(log_c[base+i] - log_c[base]), 32'(i));
      end
    end

    // Stalled responses fill the credit
    base = log_d.size();
    resp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h40 + 32'(acc * 4);
      if (req_ready) acc++;
      tick();
    end
    req_valid = 1'b0;
    chk("stall_accepted", 32'(acc), 32'(8));
    chk("stall_ready_low", 32'(req_ready), 32'(0));
    resp_ready = 1'b1;
    #1;
    chk("no_comb_ready", 32'(req_ready), 32'(0));
    tick();
    chk("ready_after_pop", 32'(req_ready), 32'(1));
    repeat (10) tick();
    chk("drain_count", 32'(log_d.size() - base), 32'(8));
    for (int i = 0; i < 8; i++) begin
      if (base + i < log_d.size()) begin
        chk("drain_data", log_d[base+i], pattern(16 + i));
        chk("drain_consecutive", 32'(log_c[base+i] - log_c[base]), 32'(i));
      end
    end

    // Reset with 3 loads in flight and 2 buffered
    resp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'(i * 4);
      tick();
    end
    req_valid = 1'b0;
    chk("pre_rst_valid", 32'(resp_valid), 32'(1));
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", 32'(resp_valid), 32'(0));
    chk("rst_mid_ready", 32'(req_ready), 32'(0));
    chk("rst_mid_rdata", resp_rdata, 32'h0);
    tick();
    tick();
    rst = 1'b0; resp_ready = 1'b1;
    #1;
    chk("rst_mid_release_ready", 32'(req_ready), 32'(1));
    base = log_d.size();
    repeat (8) tick();
    chk("no_resp_after_rst", 32'(log_d.size() - base), 32'(0));

    // Unaligned load
    base = log_d.size();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h20;
    tick();
    a0 = mem_addr;
    chk("aligned_addr", a0, 32'h8);
    req_addr = 32'h102;
    tick();
    req_valid = 1'b0;
`ifdef MEMCTRL_ERR_EN
    chk("err_load_addr_hold", mem_addr, a0);
`else
    chk("load102_addr", mem_addr, 32'h40);
`endif
    repeat (6) tick();
    chk("load102_count", 32'(log_d.size() - base), 32'(2));
    if (log_d.size() >= base + 2) begin
`ifdef MEMCTRL_ERR_EN
      chk("load102_rdata", log_d[base+1], 32'h0);
      chk("load102_err", 32'(log_e[base+1]), 32'(1));
`else
      chk("load102_rdata", log_d[base+1], 32'hDEADBEEF);
      chk("load102_err", 32'(log_e[base+1]), 32'(0));
`endif
    end

    // Out-of-range store
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0010_0000; req_wdata = 32'h1234_5678;
    tick();
    req_valid = 1'b0;
`ifdef MEMCTRL_ERR_EN
    chk("err_store_we", 32'(mem_we), 32'(0));
    chk("err_store_sticky", 32'(err_sticky), 32'(1));
    tick();
    chk("err_sticky_holds", 32'(err_sticky), 32'(1));
`else
    chk("far_store_we", 32'(mem_we), 32'(1));
    chk("far_store_sticky", 32'(err_sticky), 32'(0));
    tick();
`endif
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Load/store front end for the `bram` data memory: accepts byte-addressed requests from the core over a valid/ready handshake, drives the BRAM port, and tracks each read through the BRAM's fixed 2-cycle read latency. Read data is returned in order on a valid/ready response channel, buffered so that the core can stall responses without losing data. Sits between the core's memory stage and `bram`.

## Interface
- `DEPTH`, 8: response FIFO entries; power of two, ≥ 2.
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous reset, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid && req_ready` at a rising edge.
- `req_we` in 1: 1 for store, 0 for load.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data.
- `resp_valid` out 1: load response present.
- `resp_ready` in 1: response consumed when `resp_valid && resp_ready`.
- `resp_rdata` out 32: load data.
- `resp_err` out 1: response is an error; tied 0 without `MEMCTRL_ERR_EN`.
- `err_sticky` out 1: set by an errored store, cleared only by reset; tied 0 without the macro.
- `mem_addr` out 32: word address to `bram`, equal to `{14'b0, req_addr[19:2]}`.
- `mem_din` out 32: to `bram`.
- `mem_we` out 1: to `bram`.
- `mem_dout` in 32: from `bram`, valid 2 edges after `mem_addr` is presented.

## Operation
- Issue stage:
  - `mem_addr`, `mem_din` and `mem_we` are registered from the accepted request.
  - When no request is accepted, `mem_we` returns to 0 and `mem_addr`/`mem_din` hold their values.
- Tracking:
  - A 3-bit shift register p0→p1→p2 carries a load marker (plus err bit with macro). It is set at acceptance.
  - When p2 is set, `mem_dout` is valid that cycle and is pushed into the response FIFO at the next edge.
  - Stores are not tracked and produce no response.
- Credit:
  - `inflight` is the count of set load markers (0..3).
  - `req_ready = (fifo_count + inflight) < DEPTH`, for both loads and stores.
  - `req_ready` has no combinational path from `resp_ready`. The FIFO therefore never overflows.
- Ordering:
  - Requests are strictly in order. A store accepted in cycle N is written at edge N+1.
  - A load accepted in cycle N+1 or later reads the new data.
- FIFO:
  - `resp_valid = !empty`, with head data on `resp_rdata`/`resp_err`.
  - A push and a pop on the same edge leave `fifo_count` unchanged.
  - Read and write pointers wrap modulo `DEPTH`.
- Reset (any time, including mid-operation):
  - All markers, the FIFO and pointers are cleared. `mem_we`, `mem_addr`, `mem_din`, `resp_rdata`, `resp_err` and `err_sticky` go to 0, and `resp_valid` goes to 0.
  - In-flight loads are dropped. `bram` contents are untouched.
  - A store whose `mem_we` is cleared by reset before its edge is not performed.
  - `req_ready` is 0 while `rst` is high and 1 in the first cycle after release.

## Timing
- Load:
  - Handshake in cycle 0.
  - `mem_addr` is valid in cycle 1, `bram` internal register in cycle 2, and `mem_dout`/p2 in cycle 3.
  - `resp_valid` rises in cycle 4, so latency is 4 cycles.
- Store: `mem_we` is high in cycle 1 only, and memory is updated at the end of cycle 1.
- Throughput: one request per cycle while `resp_ready` is high and `DEPTH` ≥ 5.
- A held `resp_ready` = 0 stalls `req_ready` once the FIFO plus in-flight count reaches `DEPTH`.

## Configuration
- `MEMCTRL_ERR_EN` defined:
  - A request with `req_addr[1:0] != 0` or `req_addr[31:20] != 0` is errored and never reaches `bram`: `mem_we` stays 0 and `mem_addr` is not updated.
  - An errored load travels the same 4-cycle pipeline and returns `resp_rdata = 0`, `resp_err = 1`.
  - An errored store sets `err_sticky`.
- Undefined:
  - Those address bits are ignored and every request is issued.
  - `resp_err` and `err_sticky` are constant 0.

## Structure
- `memctrl_pkg` holds:
  - `BRAM_LAT = 2`
  - `WORD_AW = 18`
  - `PIPE_STAGES = 3`
  - the `resp_t` struct {`rdata[31:0]`, `err`}
- Sub-module `resp_fifo` (parameter `DEPTH`, `resp_t` in/out, push/pop, `count`, `empty`) holds the response buffer. All control logic is in `mem_ctrl`.

## Test plan
- Store 0xDEADBEEF @0x100, then load @0x100 in the next cycle, with `resp_ready` = 1 → `mem_addr` = 0x40; `resp_rdata` = 0xDEADBEEF with `resp_valid` 4 cycles after the load handshake.
- 16 back-to-back loads of preloaded words 0..15 with `resp_ready` = 1 and `DEPTH` = 8 → `req_ready` stays 1 throughout; responses arrive in order on 16 consecutive cycles.
- `resp_ready` = 0 while loads are issued → exactly 8 loads accepted, then `req_ready` = 0. Raising `resp_ready` drains 8 responses in order and re-raises `req_ready` after the first pop.
- Assert `rst` while 3 loads are in flight and 2 are buffered → `resp_valid` = 0 immediately; no response appears after release; `req_ready` = 1 in the first cycle after release.
- With `MEMCTRL_ERR_EN`:
  - load @0x102 → `resp_err` = 1, `resp_rdata` = 0, `mem_addr` unchanged.
  - store @0x0010_0000 → `mem_we` stays 0, `err_sticky` = 1.
- Without `MEMCTRL_ERR_EN`: load @0x102 → reads word 0x40; `resp_err` = 0.
